// File: rtl/dram64k_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// dram64k_ctrl_pkg
// FSM encoding, phase lengths and address field helpers for the DRAM sequencer.
// Rev 1.0
// ============================================================================
package dram64k_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ROW   = 3'd1,
    ST_COL   = 3'd2,
    ST_DATA  = 3'd3,
    ST_LATCH = 3'd4,
    ST_PRE   = 3'd5,
    ST_REF_A = 3'd6,
    ST_REF_B = 3'd7
  } state_t;

  localparam int unsigned C_ACCESS_CYCLES  = 6;
  localparam int unsigned C_REFRESH_CYCLES = 4;

  // The DRAM is addressed as {COL,ROW}: row in the low byte.
  function automatic logic [7:0] row_of(input logic [15:0] addr);
    return addr[7:0];
  endfunction

  function automatic logic [7:0] col_of(input logic [15:0] addr);
    return addr[15:8];
  endfunction

endpackage
`default_nettype wire

// File: rtl/dram64k_ctrl_if.sv
`default_nettype none
// ============================================================================
// dram64k_ctrl_if
// CPU request/acknowledge bus plus the multiplexed DRAM strobe/data bus.
// Rev 1.0
// ============================================================================
interface dram64k_ctrl_if;

  logic        i_REQ;
  logic        i_WE;
  logic [15:0] i_A;
  logic [7:0]  i_D;
  logic [7:0]  o_Q;
  logic        o_ACK;
  logic        o_BUSY;
  logic [7:0]  o_ADDR;
  logic [7:0]  o_DOUT;
  logic [7:0]  i_DIN;
  logic        o_RAS_n;
  logic        o_CAS_n;
  logic        o_WR_n;

  modport master (
    output i_REQ, i_WE, i_A, i_D, i_DIN,
    input  o_Q, o_ACK, o_BUSY, o_ADDR, o_DOUT, o_RAS_n, o_CAS_n, o_WR_n
  );

  modport slave (
    input  i_REQ, i_WE, i_A, i_D, i_DIN,
    output o_Q, o_ACK, o_BUSY, o_ADDR, o_DOUT, o_RAS_n, o_CAS_n, o_WR_n
  );

endinterface
`default_nettype wire

// File: rtl/dram64k_refresh_timer.sv
`default_nettype none
// ============================================================================
// dram64k_refresh_timer
// Free-running refresh interval counter, refresh row counter and pending flag.
// Rev 1.0
// ============================================================================
module dram64k_refresh_timer #(
  parameter int unsigned REFRESH_INTERVAL = 60
) (
  input  logic       i_MCLK,
  input  logic       i_RST_n,
  input  logic       i_clear,
  output logic       o_pending,
  output logic [7:0] o_row
);

  localparam logic [15:0] C_LAST = 16'(REFRESH_INTERVAL - 1);

  logic [15:0] r_count;

  always_ff @(posedge i_MCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      r_count   <= 16'd0;
      o_pending <= 1'b0;
      o_row     <= 8'd0;
    end else begin
      r_count <= (r_count == C_LAST) ? 16'd0 : r_count + 16'd1;
      // A tick landing while a refresh is still outstanding is simply lost.
      if (i_clear) begin
        o_pending <= 1'b0;
        o_row     <= o_row + 8'd1;
      end else if (r_count == C_LAST) begin
        o_pending <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/dram64k_ctrl.sv
`default_nettype none
// ============================================================================
// dram64k_ctrl
// RAS/CAS/WR sequencer for a 64k x 8 DRAM; RAS-only refresh under
// DRAM64K_CTRL_REFRESH_EN.
// Rev 1.0
// ============================================================================
module dram64k_ctrl
  import dram64k_ctrl_pkg::*;
#(
  parameter int unsigned REFRESH_INTERVAL = 60
) (
  input  logic          i_MCLK,
  input  logic          i_RST_n,
  dram64k_ctrl_if.slave bus
);

  if ((REFRESH_INTERVAL < 8) || (REFRESH_INTERVAL > 65535)) begin : g_bad_interval
    $error("dram64k_ctrl: REFRESH_INTERVAL out of range 8..65535");
  end

  state_t      r_state;
  logic        r_we;
  logic [15:0] r_addr;
  logic        w_ref_pending;
  logic [7:0]  w_ref_row;

`ifdef DRAM64K_CTRL_REFRESH_EN
  dram64k_refresh_timer #(
    .REFRESH_INTERVAL (REFRESH_INTERVAL)
  ) u_refresh (
    .i_MCLK    (i_MCLK),
    .i_RST_n   (i_RST_n),
    .i_clear   (r_state == ST_REF_B),
    .o_pending (w_ref_pending),
    .o_row     (w_ref_row)
  );
`else
  assign w_ref_pending = 1'b0;
  assign w_ref_row     = 8'd0;
`endif

  always_ff @(posedge i_MCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      r_state     <= ST_IDLE;
      r_we        <= 1'b0;
      r_addr      <= 16'd0;
      bus.o_RAS_n <= 1'b1;
      bus.o_CAS_n <= 1'b1;
      bus.o_WR_n  <= 1'b1;
      bus.o_ADDR  <= 8'd0;
      bus.o_DOUT  <= 8'd0;
      bus.o_Q     <= 8'd0;
      bus.o_ACK   <= 1'b0;
      bus.o_BUSY  <= 1'b0;
    end else begin
      bus.o_ACK <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_ref_pending) begin
            r_state     <= ST_REF_A;
            bus.o_ADDR  <= w_ref_row;
            bus.o_RAS_n <= 1'b0;
            bus.o_BUSY  <= 1'b1;
          end else if (bus.i_REQ) begin
            r_state     <= ST_ROW;
            r_we        <= bus.i_WE;
            r_addr      <= bus.i_A;
            bus.o_DOUT  <= bus.i_D;
            bus.o_ADDR  <= row_of(bus.i_A);
            bus.o_RAS_n <= 1'b0;
            bus.o_BUSY  <= 1'b1;
          end
        end
        ST_ROW: begin
          r_state     <= ST_COL;
          bus.o_ADDR  <= col_of(r_addr);
          bus.o_CAS_n <= 1'b0;
        end
        ST_COL: begin
          r_state    <= ST_DATA;
          bus.o_WR_n <= ~r_we;
        end
        ST_DATA: begin
          r_state    <= ST_LATCH;
          bus.o_WR_n <= 1'b1;
        end
        ST_LATCH: begin
          r_state     <= ST_PRE;
          bus.o_ACK   <= 1'b1;
          bus.o_RAS_n <= 1'b1;
          bus.o_CAS_n <= 1'b1;
          if (!r_we) begin
            bus.o_Q <= bus.i_DIN;
          end
        end
        ST_PRE: begin
          r_state    <= ST_IDLE;
          bus.o_BUSY <= 1'b0;
        end
        ST_REF_A: begin
          r_state <= ST_REF_B;
        end
        ST_REF_B: begin
          r_state     <= ST_PRE;
          bus.o_RAS_n <= 1'b1;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/dram64k_ctrl.md
# dram64k_ctrl

Sequencer directly upstream of the 64k×8 multiplexed-address DRAM (4164 ×8) model. Converts a simple request/acknowledge CPU-side access into RAS/CAS/WR strobe sequences with row/column address multiplexing. Also issues periodic RAS-only refresh cycles from an internal row counter. Row = address bits [7:0], column = bits [15:8], matching the DRAM's {COL,ROW} addressing.

## Interface
- REFRESH_INTERVAL, 60: i_MCLK cycles between refresh requests; legal range 8..65535.
- i_MCLK  in  1  system clock; all logic on rising edge.
- i_RST_n  in  1  asynchronous active-low reset.
- i_REQ  in  1  access request, level; sampled only in IDLE.
- i_WE  in  1  1 = write, 0 = read; latched at acceptance.
- i_A  in  16  byte address; latched at acceptance.
- i_D  in  8  write data; latched at acceptance.
- o_Q  out  8  read data; valid from the ACK cycle until the next read completes.
- o_ACK  out  1  one-cycle completion pulse, reads and writes.
- o_BUSY  out  1  high in every state except IDLE.
- o_ADDR  out  8  multiplexed DRAM address.
- o_DOUT  out  8  write data to DRAM i_DIN.
- i_DIN  in  8  read data from DRAM o_DOUT.
- o_RAS_n, o_CAS_n, o_WR_n  out  1 each  DRAM strobes, active low.

## Operation
- All outputs are registered. Reset values: o_RAS_n, o_CAS_n, o_WR_n = 1; o_ADDR, o_DOUT, o_Q = 0; o_ACK, o_BUSY = 0. Internal state: IDLE, refresh counter 0, refresh row 0, refresh pending 0.
- FSM states: IDLE, ROW, COL, DATA, LATCH, PRE, REF_A, REF_B.
- IDLE: refresh pending has priority and goes to REF_A. Otherwise i_REQ=1 goes to ROW, latching i_WE, i_A, and i_D into o_DOUT. Otherwise the FSM stays in IDLE.
- ROW: o_ADDR = A[7:0], o_RAS_n = 0. Next state COL.
- COL: o_ADDR = A[15:8], o_CAS_n = 0. Next state DATA.
- DATA: o_WR_n = 0 for writes only, for exactly one cycle. Next state LATCH.
- LATCH: o_WR_n = 1. Next state PRE.
- PRE entry from LATCH: o_Q <= i_DIN on reads, o_ACK = 1, o_RAS_n = o_CAS_n = 1.
- PRE entry from REF_B: o_RAS_n = 1.
- PRE then returns to IDLE.
- REF_A: o_ADDR = refresh row, o_RAS_n = 0; o_CAS_n stays 1. Next state REF_B. REF_B holds RAS low, then goes to PRE. On leaving REF_B the refresh row increments, wrapping 255→0, and the pending flag clears.
- The refresh counter runs freely in every state. It sets pending when it reaches REFRESH_INTERVAL−1, then wraps to 0. A tick while pending is already set is dropped; there is no queue.
- Back-to-back: if i_REQ is still high in IDLE after an ACK, a new access starts. The requester must drop i_REQ in the ACK cycle to avoid a repeat.
- Reset asserted mid-access: strobes return high asynchronously, the access is aborted, and no ACK is issued.

## Timing
- Edge numbering: acceptance edge E0; at E0 the FSM enters ROW, so RAS is low and the row address is driven after E0.
- The DRAM latches the row at E1 and the column at E2.
- Write: WR_n is low between E2 and E3, so the write commits at E3.
- Read: DRAM o_DOUT is valid after E3 and captured into o_Q at E4.
- o_ACK is high for the cycle after E4. IDLE is reached at E5.
- Access period: 6 cycles. Refresh occupancy: 4 cycles, with RAS low for 2 cycles.
- Worst-case request latency: refresh immediately followed by an access, 4 + 5 = 9 cycles to ACK.

## Configuration
- DRAM64K_CTRL_REFRESH_EN defined: refresh counter, row counter, pending flag and REF_A/REF_B are compiled in.
- DRAM64K_CTRL_REFRESH_EN undefined: the refresh logic is removed and IDLE arbitrates only i_REQ. RAS never falls without a following CAS. REFRESH_INTERVAL is ignored.

## Structure
- Package dram64k_ctrl_pkg holds:
  - the FSM state enum;
  - the phase-length constants (access 6, refresh 4);
  - the row/column field slices of the 16-bit address.
- Sub-module dram64k_refresh_timer contains the interval counter, the refresh row counter, the pending flag and its clear input.

## Test plan
- Write 0xA5 to 0x1234 with the DRAM model attached: o_ADDR = 0x34 with RAS low after E0, then 0x12 with CAS low after E1; WR_n low for exactly one cycle after E2; o_ACK one cycle after E4. A following read of 0x1234 gives o_Q = 0xA5.
- Idle with REFRESH_INTERVAL=60: a RAS-only pulse of 2 cycles every 60 cycles, CAS and WR_n high, o_ADDR = 0, 1, 2, …
- 257 refreshes: the row sequence wraps 0xFF → 0x00.
- i_REQ rising in the same cycle that pending sets: the refresh runs first, and ACK arrives 9 cycles after the request was seen in IDLE.
- i_REQ held high across 3 writes: ACKs 6 cycles apart; the memory holds all 3 bytes.
- i_RST_n pulsed in COL: RAS_n and CAS_n go high immediately, no ACK, o_BUSY = 0, and the next request completes normally.
